sram_write_scoreboard: RTL and testbench
========================================

Name: sram_write_scoreboard

Overview:
Synthesizable, parametrised monitor on the external SRAM write bus. It checks each decoder write against NUM_REGIONS configurable address regions (e.g. R/G/B or Y/U/V planes). Per region it counts writes, flags out-of-order and excess writes, and builds an order-dependent data signature, then compares it with an expected value. It sits beside the top-level SRAM mux and gives an on-chip pass/fail for milestone runs without the simulation-only verification array.

Parameters:
ADDR_W, 18, SRAM word address width
DATA_W, 16, SRAM data width and signature width
NUM_REGIONS, 3, number of monitored regions
CNT_W, 18, per-region length/count width
ERR_W, 16, width of the saturating error counters

Ports:
Clock_50  in  1  system clock
Resetn  in  1  asynchronous active-low reset
Arm_i  in  1  single-cycle pulse; clears statistics and starts monitoring
Abort_i  in  1  single-cycle pulse; returns to idle
Seq_mode_i  in  1  1 = each region must be written strictly base, base+1, …
Region_base_i  in  NUM_REGIONS*ADDR_W  region start addresses; region k in slice k
Region_len_i  in  NUM_REGIONS*CNT_W  region lengths in words; must be nonzero
Expected_sig_i  in  NUM_REGIONS*DATA_W  expected final signature per region
SRAM_address_i  in  ADDR_W  observed SRAM address
SRAM_write_data_i  in  DATA_W  observed write data
SRAM_we_n_i  in  1  observed active-low write enable
Busy_o  out  1  high in RUN or CHECK
Done_o  out  1  high in DONE
Pass_o  out  1  valid while Done_o is high
Region_done_o  out  NUM_REGIONS  count == length, per region
Region_sig_o  out  NUM_REGIONS*DATA_W  current signatures
Oor_err_cnt_o  out  ERR_W  writes matching no region
Order_err_cnt_o  out  ERR_W  sequential-mode address violations
Excess_err_cnt_o  out  ERR_W  writes to a region already complete
Err_o  out  1  sticky; any error since Arm
First_err_addr_o  out  ADDR_W  address of the first error since Arm

Behaviour:
- Reset: state IDLE. All counts, signatures, error counters, Err_o, First_err_addr_o, Busy_o, Done_o and Pass_o are 0.
- FSM states: IDLE, RUN, CHECK, DONE.
  - Arm_i in IDLE or DONE: clears all statistics and the pipeline; next state RUN.
  - Arm_i in RUN or CHECK: ignored.
  - Abort_i in any state: next state IDLE; statistics are held for readback. Abort_i has priority over Arm_i.
  - RUN → CHECK when every region is done and the pipeline stage is empty.
  - CHECK: one cycle; registers Pass_o = (all signatures match) && !Err_o. Next state DONE.
  - DONE: holds until Arm_i or Abort_i.
- Pipeline:
  - Stage 1 registers {we, addr, data} on every edge. Its valid bit is set only in RUN with SRAM_we_n_i == 0.
  - Stage 2 classifies the write and updates statistics.
  - Done_o rises on the 3rd edge after the edge that sampled the final write.
- Region match: base ≤ addr < base+len, computed at ADDR_W+1 bits so there is no wrap-around. On overlapping regions, the lowest index wins.
- Classification of a stage-2 write:
  - No match: Oor_err_cnt +1.
  - Match and count == len: Excess_err_cnt +1. Count and signature are unchanged.
  - Otherwise, valid write:
    - sig ← rotl1(sig) XOR data.
    - count +1.
    - If Seq_mode_i and addr ≠ base+count: Order_err_cnt +1. The write is still accumulated.
- Error counters saturate at all-ones and never wrap.
- The first error of any kind sets Err_o and captures First_err_addr_o. Later errors do not overwrite it.
- Writes in IDLE, CHECK or DONE are ignored.
- Writes still in stage 1 at the RUN→IDLE abort are discarded.
- Region configuration inputs must be stable from Arm until DONE; they are not registered.

Decomposition:
- Package sram_scoreboard_pkg: state enum (IDLE, RUN, CHECK, DONE), rotl1 signature function, saturating-increment function.
- Sub-module sram_region_tracker, generated NUM_REGIONS times. It holds the range match, count, signature and per-region done/excess/order flags.
- Top level: FSM, priority match, error counters, first-error capture.

Test Plan:
- Regions {0,4},{16,4},{32,4}, expected sig 0x0002 each, Seq_mode 1. Arm, then write data 1,2,3,4 sequentially to each region → Done_o on 3rd edge after the last write; Pass_o = 1; all error counts 0.
- Same setup, one extra write to address 2 after region 0 completes → Excess_err_cnt = 1; Err_o = 1; First_err_addr_o = 2; Pass_o = 0.
- Write to address 100 mid-run → Oor_err_cnt = 1; run still finishes with Pass_o = 0.
- Seq_mode 1, region 0 written in order 1,0,2,3 → Order_err_cnt = 2; First_err_addr_o = 1. With Seq_mode 0 the same writes give Order_err_cnt = 0.
- Force Oor_err_cnt to 0xFFFE, then issue 3 out-of-region writes → counter holds at 0xFFFF.
- Abort_i after 2 writes → IDLE; counts held at 2. Next Arm_i → all counts and signatures 0. Deassert Resetn mid-RUN → all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/sram_scoreboard_pkg.sv
// Shared types and helpers for the SRAM write scoreboard: FSM state encoding,
// the signature rotate and the saturating counter increment.
package sram_scoreboard_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } sb_state_t;

  // Helpers work on a wide carrier so any DATA_W/ERR_W up to MAX_W can share them.
  localparam int MAX_W = 64;

  function automatic logic [MAX_W-1:0] rotl1(input logic [MAX_W-1:0] value,
                                             input int width);
    logic [MAX_W-1:0] result;
    result = '0;
    for (int i = 1; i < MAX_W; i++) begin
      if (i < width) result[i] = value[i-1];
    end
    for (int j = 0; j < MAX_W; j++) begin
      if (j == width - 1) result[0] = value[j];
    end
    return result;
  endfunction

  function automatic logic [MAX_W-1:0] sat_inc(input logic [MAX_W-1:0] value,
                                               input int width);
    logic [MAX_W-1:0] mask;
    mask = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < width) mask[i] = 1'b1;
    end
    return (value == mask) ? value : value + MAX_W'(1);
  endfunction

endpackage

// File: rtl/sram_region_tracker.sv
// One monitored SRAM region: range match, write count, order-dependent
// signature and the per-write done/excess/order flags.
module sram_region_tracker
  import sram_scoreboard_pkg::*;
#(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 18
) (
  input  logic              clock_50,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              update,
  input  logic              seq_mode,
  input  logic [ADDR_W-1:0] base,
  input  logic [CNT_W-1:0]  len,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  output logic              hit,
  output logic              done,
  output logic              excess,
  output logic              order_err,
  output logic [DATA_W-1:0] sig
);

  // One guard bit above the wider operand so base+len never wraps.
  localparam int SUM_W = ((ADDR_W > CNT_W) ? ADDR_W : CNT_W) + 1;

  logic [CNT_W-1:0] count;
  logic [SUM_W-1:0] addr_x;
  logic [SUM_W-1:0] base_x;
  logic [SUM_W-1:0] end_x;
  logic [SUM_W-1:0] next_x;

  always_comb begin
    addr_x    = SUM_W'(addr);
    base_x    = SUM_W'(base);
    end_x     = base_x + SUM_W'(len);
    next_x    = base_x + SUM_W'(count);
    hit       = (addr_x >= base_x) && (addr_x < end_x);
    done      = (count == len);
    excess    = hit && done;
    order_err = hit && !done && seq_mode && (addr_x != next_x);
  end

  // Out-of-order writes still accumulate; only excess writes are dropped.
  always_ff @(posedge clock_50 or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      sig   <= '0;
    end else if (clear) begin
      count <= '0;
      sig   <= '0;
    end else if (update && !done) begin
      count <= count + CNT_W'(1);
      sig   <= DATA_W'(rotl1(MAX_W'(sig), DATA_W)) ^ data;
    end
  end

endmodule

// File: rtl/sram_write_scoreboard.sv
// On-chip monitor of the SRAM write bus: two-stage capture/classify pipeline,
// per-region trackers, saturating error counters and a final pass/fail.
module sram_write_scoreboard
  import sram_scoreboard_pkg::*;
#(
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 16,
  parameter int NUM_REGIONS = 3,
  parameter int CNT_W       = 18,
  parameter int ERR_W       = 16
) (
  input  logic                          Clock_50,
  input  logic                          Resetn,
  input  logic                          Arm_i,
  input  logic                          Abort_i,
  input  logic                          Seq_mode_i,
  input  logic [NUM_REGIONS*ADDR_W-1:0] Region_base_i,
  input  logic [NUM_REGIONS*CNT_W-1:0]  Region_len_i,
  input  logic [NUM_REGIONS*DATA_W-1:0] Expected_sig_i,
  input  logic [ADDR_W-1:0]             SRAM_address_i,
  input  logic [DATA_W-1:0]             SRAM_write_data_i,
  input  logic                          SRAM_we_n_i,
  output logic                          Busy_o,
  output logic                          Done_o,
  output logic                          Pass_o,
  output logic [NUM_REGIONS-1:0]        Region_done_o,
  output logic [NUM_REGIONS*DATA_W-1:0] Region_sig_o,
  output logic [ERR_W-1:0]              Oor_err_cnt_o,
  output logic [ERR_W-1:0]              Order_err_cnt_o,
  output logic [ERR_W-1:0]              Excess_err_cnt_o,
  output logic                          Err_o,
  output logic [ADDR_W-1:0]             First_err_addr_o
);

  sb_state_t state, state_nxt;

  logic                   s1_valid;
  logic [ADDR_W-1:0]      s1_addr;
  logic [DATA_W-1:0]      s1_data;
  logic                   arm_clear;
  logic                   s2_valid;
  logic [NUM_REGIONS-1:0] hit;
  logic [NUM_REGIONS-1:0] excess;
  logic [NUM_REGIONS-1:0] order_err;
  logic [NUM_REGIONS-1:0] winner;
  logic                   any_hit;
  logic                   win_excess;
  logic                   win_order;
  logic                   sig_ok;
  logic                   pass_q;

  assign arm_clear = Arm_i && !Abort_i && ((state == IDLE) || (state == DONE));
  // A write still in stage 1 when Abort lands is discarded, not classified.
  assign s2_valid  = s1_valid && (state == RUN) && !Abort_i;

  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (Abort_i) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (Arm_i) state_nxt = RUN;
        RUN:     if ((&Region_done_o) && !s1_valid) state_nxt = CHECK;
        CHECK:   state_nxt = DONE;
        DONE:    if (Arm_i) state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      s1_data  <= '0;
    end else begin
      s1_valid <= (state == RUN) && !SRAM_we_n_i && !Abort_i;
      s1_addr  <= SRAM_address_i;
      s1_data  <= SRAM_write_data_i;
    end
  end

  for (genvar k = 0; k < NUM_REGIONS; k++) begin : g_region
    sram_region_tracker #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
    ) u_tracker (
      .clock_50  (Clock_50),
      .rst_n     (Resetn),
      .clear     (arm_clear),
      .update    (s2_valid && winner[k]),
      .seq_mode  (Seq_mode_i),
      .base      (Region_base_i[k*ADDR_W +: ADDR_W]),
      .len       (Region_len_i[k*CNT_W +: CNT_W]),
      .addr      (s1_addr),
      .data      (s1_data),
      .hit       (hit[k]),
      .done      (Region_done_o[k]),
      .excess    (excess[k]),
      .order_err (order_err[k]),
      .sig       (Region_sig_o[k*DATA_W +: DATA_W])
    );
  end

  // Overlapping regions resolve to the lowest index.
  always_comb begin
    winner  = '0;
    any_hit = 1'b0;
    for (int k = 0; k < NUM_REGIONS; k++) begin
      if (hit[k] && !any_hit) begin
        winner[k] = 1'b1;
        any_hit   = 1'b1;
      end
    end
    win_excess = |(winner & excess);
    win_order  = |(winner & order_err);
  end

  always_comb begin
    sig_ok = 1'b1;
    for (int k = 0; k < NUM_REGIONS; k++) begin
      if (Region_sig_o[k*DATA_W +: DATA_W] != Expected_sig_i[k*DATA_W +: DATA_W])
        sig_ok = 1'b0;
    end
  end

  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      Oor_err_cnt_o    <= '0;
      Order_err_cnt_o  <= '0;
      Excess_err_cnt_o <= '0;
      Err_o            <= 1'b0;
      First_err_addr_o <= '0;
    end else if (arm_clear) begin
      Oor_err_cnt_o    <= '0;
      Order_err_cnt_o  <= '0;
      Excess_err_cnt_o <= '0;
      Err_o            <= 1'b0;
      First_err_addr_o <= '0;
    end else if (s2_valid) begin
      if (!any_hit)
        Oor_err_cnt_o <= ERR_W'(sat_inc(MAX_W'(Oor_err_cnt_o), ERR_W));
      else if (win_excess)
        Excess_err_cnt_o <= ERR_W'(sat_inc(MAX_W'(Excess_err_cnt_o), ERR_W));
      else if (win_order)
        Order_err_cnt_o <= ERR_W'(sat_inc(MAX_W'(Order_err_cnt_o), ERR_W));
      if ((!any_hit || win_excess || win_order) && !Err_o) begin
        Err_o            <= 1'b1;
        First_err_addr_o <= s1_addr;
      end
    end
  end

  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn)              pass_q <= 1'b0;
    else if (arm_clear)       pass_q <= 1'b0;
    else if (state == CHECK)  pass_q <= sig_ok && !Err_o;
  end

  assign Busy_o = (state == RUN) || (state == CHECK);
  assign Done_o = (state == DONE);
  assign Pass_o = pass_q && (state == DONE);

endmodule

// File: tb/tb_sram_write_scoreboard.sv
// Self-checking bench: directed scenarios plus randomized runs compared against
// a region/count/signature reference model kept in the bench.
module tb_sram_write_scoreboard;

  localparam int ADDR_W = 18;
  localparam int DATA_W = 16;
  localparam int NR     = 3;
  localparam int CNT_W  = 18;
  localparam int ERR_W  = 4;

  logic                   Clock_50 = 1'b0;
  logic                   Resetn = 1'b0;
  logic                   Arm_i = 1'b0;
  logic                   Abort_i = 1'b0;
  logic                   Seq_mode_i = 1'b0;
  logic [NR*ADDR_W-1:0]   Region_base_i = '0;
  logic [NR*CNT_W-1:0]    Region_len_i = '0;
  logic [NR*DATA_W-1:0]   Expected_sig_i = '0;
  logic [ADDR_W-1:0]      SRAM_address_i = '0;
  logic [DATA_W-1:0]      SRAM_write_data_i = '0;
  logic                   SRAM_we_n_i = 1'b1;
  logic                   Busy_o;
  logic                   Done_o;
  logic                   Pass_o;
  logic [NR-1:0]          Region_done_o;
  logic [NR*DATA_W-1:0]   Region_sig_o;
  logic [ERR_W-1:0]       Oor_err_cnt_o;
  logic [ERR_W-1:0]       Order_err_cnt_o;
  logic [ERR_W-1:0]       Excess_err_cnt_o;
  logic                   Err_o;
  logic [ADDR_W-1:0]      First_err_addr_o;

  sram_write_scoreboard #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .NUM_REGIONS (NR),
    .CNT_W       (CNT_W),
    .ERR_W       (ERR_W)
  ) dut (
    .Clock_50          (Clock_50),
    .Resetn            (Resetn),
    .Arm_i             (Arm_i),
    .Abort_i           (Abort_i),
    .Seq_mode_i        (Seq_mode_i),
    .Region_base_i     (Region_base_i),
    .Region_len_i      (Region_len_i),
    .Expected_sig_i    (Expected_sig_i),
    .SRAM_address_i    (SRAM_address_i),
    .SRAM_write_data_i (SRAM_write_data_i),
    .SRAM_we_n_i       (SRAM_we_n_i),
    .Busy_o            (Busy_o),
    .Done_o            (Done_o),
    .Pass_o            (Pass_o),
    .Region_done_o     (Region_done_o),
    .Region_sig_o      (Region_sig_o),
    .Oor_err_cnt_o     (Oor_err_cnt_o),
    .Order_err_cnt_o   (Order_err_cnt_o),
    .Excess_err_cnt_o  (Excess_err_cnt_o),
    .Err_o             (Err_o),
    .First_err_addr_o  (First_err_addr_o)
  );

  always #10 Clock_50 = ~Clock_50;

  int checks = 0;
  int errors = 0;

  int               base [NR];
  int               len [NR];
  logic [DATA_W-1:0] expSig [NR];
  int               mCnt [NR];
  logic [DATA_W-1:0] mSig [NR];
  int               mOor;
  int               mOrd;
  int               mExc;
  bit               mErr;
  int               mFirst;
  bit               mRun;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock_50);
    #1;
  endtask

  function automatic int satInc(input int v);
    return (v >= (1 << ERR_W) - 1) ? v : v + 1;
  endfunction

  task automatic noteErr(input int a);
    if (!mErr) begin
      mErr   = 1'b1;
      mFirst = a;
    end
  endtask

  // Reference rules: lowest matching region wins; full region -> excess;
  // otherwise accumulate, flagging an order error in sequential mode.
  task automatic modelWrite(input int a, input logic [DATA_W-1:0] d);
    int hitK;
    hitK = -1;
    for (int k = 0; k < NR; k++)
      if (hitK < 0 && a >= base[k] && a < base[k] + len[k]) hitK = k;
    if (hitK < 0) begin
      mOor = satInc(mOor);
      noteErr(a);
    end else if (mCnt[hitK] == len[hitK]) begin
      mExc = satInc(mExc);
      noteErr(a);
    end else begin
      if (Seq_mode_i && a != base[hitK] + mCnt[hitK]) begin
        mOrd = satInc(mOrd);
        noteErr(a);
      end
      mSig[hitK] = DATA_W'((int'(mSig[hitK]) << 1) | (int'(mSig[hitK]) >> (DATA_W - 1))) ^ d;
      mCnt[hitK]++;
    end
  endtask

  task automatic loadConfig();
    for (int k = 0; k < NR; k++) begin
      Region_base_i[k*ADDR_W +: ADDR_W]  = ADDR_W'(base[k]);
      Region_len_i[k*CNT_W +: CNT_W]     = CNT_W'(len[k]);
      Expected_sig_i[k*DATA_W +: DATA_W] = expSig[k];
    end
  endtask

  task automatic applyStimulus(input int a, input logic [DATA_W-1:0] d, input bit track);
    SRAM_address_i    = ADDR_W'(a);
    SRAM_write_data_i = d;
    SRAM_we_n_i       = 1'b0;
    tick();
    SRAM_we_n_i = 1'b1;
    if (track && mRun) modelWrite(a, d);
  endtask

  task automatic armRun();
    Arm_i = 1'b1;
    tick();
    Arm_i = 1'b0;
    for (int k = 0; k < NR; k++) begin
      mCnt[k] = 0;
      mSig[k] = '0;
    end
    mOor = 0; mOrd = 0; mExc = 0; mErr = 1'b0; mFirst = 0; mRun = 1'b1;
  endtask

  task automatic writeRegion(input int k);
    for (int i = 0; i < 4; i++) applyStimulus(base[k] + i, DATA_W'(i + 1), 1'b1);
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, " oor"}, 64'(Oor_err_cnt_o), 64'(mOor));
    checkOutput({tag, " order"}, 64'(Order_err_cnt_o), 64'(mOrd));
    checkOutput({tag, " excess"}, 64'(Excess_err_cnt_o), 64'(mExc));
    checkOutput({tag, " err"}, 64'(Err_o), 64'(mErr));
    checkOutput({tag, " first"}, 64'(First_err_addr_o), mErr ? 64'(mFirst) : 64'd0);
    for (int k = 0; k < NR; k++) begin
      checkOutput($sformatf("%s sig%0d", tag, k), 64'(Region_sig_o[k*DATA_W +: DATA_W]), 64'(mSig[k]));
      checkOutput($sformatf("%s rdone%0d", tag, k), 64'(Region_done_o[k]), 64'(mCnt[k] == len[k]));
    end
  endtask

  // Called right after the last write: Done must rise on the third edge.
  task automatic finishRun(input string tag);
    int n;
    bit expPass;
    n = 0;
    while (!Done_o && n < 12) begin
      tick();
      n++;
    end
    checkOutput({tag, " done latency"}, 64'(n), 64'd3);
    expPass = !mErr;
    for (int k = 0; k < NR; k++) if (mSig[k] != expSig[k]) expPass = 1'b0;
    checkAll(tag);
    checkOutput({tag, " pass"}, 64'(Pass_o), 64'(expPass));
    checkOutput({tag, " busy"}, 64'(Busy_o), 64'd0);
    mRun = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int k = 0; k < NR; k++) begin
      base[k] = 16 * k; len[k] = 4; expSig[k] = 16'h0002;
    end
    mRun = 1'b0;
    loadConfig();
    Seq_mode_i = 1'b1;
    repeat (3) tick();
    checkOutput("reset busy", 64'(Busy_o), 64'd0);
    checkOutput("reset done", 64'(Done_o), 64'd0);
    checkOutput("reset pass", 64'(Pass_o), 64'd0);
    checkOutput("reset err", 64'(Err_o), 64'd0);
    checkOutput("reset oor", 64'(Oor_err_cnt_o), 64'd0);
    checkOutput("reset sigs", 64'(Region_sig_o), 64'd0);
    checkOutput("reset first", 64'(First_err_addr_o), 64'd0);
    Resetn = 1'b1;
    tick();

    // Clean sequential run over three 4-word regions
    armRun();
    checkOutput("clean busy", 64'(Busy_o), 64'd1);
    for (int k = 0; k < NR; k++) writeRegion(k);
    finishRun("clean");
    checkOutput("clean pass const", 64'(Pass_o), 64'd1);
    checkOutput("clean rdone const", 64'(Region_done_o), 64'h7);

    // Excess write into a completed region
    armRun();
    writeRegion(0);
    applyStimulus(2, 16'h0055, 1'b1);
    writeRegion(1); writeRegion(2);
    finishRun("excess");
    checkOutput("excess cnt const", 64'(Excess_err_cnt_o), 64'd1);
    checkOutput("excess first const", 64'(First_err_addr_o), 64'd2);

    // Out-of-range write mid-run
    armRun();
    writeRegion(0);
    applyStimulus(100, 16'h1234, 1'b1);
    writeRegion(1); writeRegion(2);
    finishRun("oor");
    checkOutput("oor cnt const", 64'(Oor_err_cnt_o), 64'd1);
    checkOutput("oor pass const", 64'(Pass_o), 64'd0);

    // Out-of-order writes, sequential and free modes
    for (int m = 1; m >= 0; m--) begin
      Seq_mode_i = m[0];
      armRun();
      applyStimulus(1, 16'd1, 1'b1); applyStimulus(0, 16'd2, 1'b1);
      applyStimulus(2, 16'd3, 1'b1); applyStimulus(3, 16'd4, 1'b1);
      writeRegion(1); writeRegion(2);
      finishRun($sformatf("order seq%0d", m));
      checkOutput($sformatf("order seq%0d cnt const", m), 64'(Order_err_cnt_o), m ? 64'd2 : 64'd0);
      checkOutput($sformatf("order seq%0d pass const", m), 64'(Pass_o), m ? 64'd0 : 64'd1);
    end
    Seq_mode_i = 1'b1;

    // Error counter saturation at all-ones
    armRun();
    for (int i = 0; i < 14; i++) applyStimulus(200, 16'h0000, 1'b1);
    tick(); tick();
    checkOutput("sat before", 64'(Oor_err_cnt_o), 64'd14);
    for (int i = 0; i < 3; i++) applyStimulus(200, 16'h0000, 1'b1);
    tick(); tick();
    checkOutput("sat after", 64'(Oor_err_cnt_o), 64'd15);
    writeRegion(0); writeRegion(1); writeRegion(2);
    finishRun("sat");

    // Abort holds statistics and drops the write still in stage 1
    armRun();
    applyStimulus(0, 16'd5, 1'b1);
    applyStimulus(1, 16'd9, 1'b1);
    tick(); tick();
    applyStimulus(2, 16'd7, 1'b0);
    Abort_i = 1'b1;
    tick();
    Abort_i = 1'b0;
    mRun = 1'b0;
    tick();
    checkOutput("abort busy", 64'(Busy_o), 64'd0);
    checkOutput("abort sig0 const", 64'(Region_sig_o[DATA_W-1:0]), 64'h0003);
    checkAll("abort");
    armRun();
    tick();
    checkAll("rearm");
    applyStimulus(0, 16'd5, 1'b1);
    applyStimulus(100, 16'd1, 1'b1);
    tick(); tick();
    checkOutput("prereset err", 64'(Err_o), 64'd1);
    #3 Resetn = 1'b0;
    #1;
    checkOutput("async busy", 64'(Busy_o), 64'd0);
    checkOutput("async err", 64'(Err_o), 64'd0);
    checkOutput("async oor", 64'(Oor_err_cnt_o), 64'd0);
    checkOutput("async sigs", 64'(Region_sig_o), 64'd0);
    checkOutput("async first", 64'(First_err_addr_o), 64'd0);
    mRun = 1'b0;
    tick();
    Resetn = 1'b1;
    tick();

    // Randomized runs against the reference model
    for (int r = 0; r < 25; r++) begin
      for (int k = 0; k < NR; k++) begin
        base[k] = 16 * k + int'($urandom_range(0, 6));
        len[k]  = int'($urandom_range(1, 6));
        expSig[k] = '0;
      end
      Seq_mode_i = 1'($urandom_range(0, 1));
      loadConfig();
      armRun();
      for (int i = 0; i < int'($urandom_range(0, 10)); i++) begin
        if ($urandom_range(0, 2) == 0) tick();
        applyStimulus(int'($urandom_range(0, 55)), DATA_W'($urandom), 1'b1);
      end
      for (int k = 0; k < NR; k++) begin
        for (int g = 0; g < 8 && mCnt[k] < len[k]; g++)
          applyStimulus(base[k] + mCnt[k], DATA_W'($urandom), 1'b1);
      end
      for (int k = 0; k < NR; k++)
        expSig[k] = ($urandom_range(0, 3) == 0) ? (mSig[k] ^ 16'h0100) : mSig[k];
      loadConfig();
      finishRun($sformatf("rand%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
